control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the DataPath: fetches each instruction through PC/MAR/MDR/IR,
//  decodes IR, and sequences the T-state control strobes (regIn/regOut, Y, Z, Hi/Lo, ALUcode)
//  the datapath benches currently drive by hand. Covers three-register ALU ops, mul/div, nop, halt.
// PARAMETERS
//  MEM_TIMEOUT   16  max cycles spent in T1 waiting for mem_ready before bus_error
//  ILLEGAL_HALT  0   1: illegal opcode halts the CPU; 0: treated as nop (illegal_op still pulses)
// PORTS
//  clock        in   1   single system clock; all state changes on posedge
//  clear        in   1   asynchronous, active-low reset
//  IR           in   32  instruction register contents from DataPath (valid from T3 onward)
//  mem_ready    in   1   memory read data valid on Mdata this cycle
//  stop         in   1   level request to halt at next instruction boundary
//  regIn        out  16  one-hot general-register load enables
//  regOut       out  16  one-hot general-register bus drive enables
//  PCOut/PCIn/IncPC, MARIn, MDRIn, MDRread, MDROut, IRIn, YIn, ZIn, ZHiOut, ZLoOut,
//  HiIn, LoIn    out  1 each  datapath strobes, names as in DataPath
//  memRead      out  1   memory read request (held while waiting)
//  ALUcode      out  5   ALU operation select
//  run          out  1   1 while executing; 0 in RESET_S and HALT_S
//  illegal_op   out  1   one-cycle pulse in T3 on an undefined opcode
//  bus_error    out  1   sticky; set on memory timeout, cleared only by clear
//  state        out  4   current state encoding (debug)
// BEHAVIOUR
//  - IR fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
//  - Opcodes: 00000-01100 ALU R[ra]<=R[rb] op R[rc], ALUcode=op; 01111 mul, 10000 div
//    (Hi/Lo<=R[rb] op R[rc], ALUcode=op); 11010 nop; 11011 halt; all others illegal.
//  - clear low (any time, incl. mid-instruction): state=RESET_S, every output 0 immediately,
//    bus_error cleared, timeout counter 0. First posedge after release: RESET_S->T0, run=1.
//  - Outputs are Moore decodes of state (+IR fields); each state lasts one clock except T1.
//  - T0: PCOut, MARIn, IncPC, ZIn.
//  - T1: ZLoOut, PCIn, memRead, MDRread, MDRIn. Stay in T1 while mem_ready=0, counter++;
//    mem_ready=1 -> T2, counter=0. Counter reaching MEM_TIMEOUT with mem_ready=0 -> bus_error=1,
//    HALT_S. mem_ready high on first T1 cycle = zero wait states.
//  - T2: MDROut, IRIn.
//  - T3: ALU/mul/div: regOut[rb], YIn. nop: -> T0 (or HALT_S if stop). halt: -> HALT_S.
//    illegal: illegal_op=1; -> HALT_S if ILLEGAL_HALT else as nop.
//  - T4: regOut[rc], ALUcode, ZIn.
//  - T5: ALU: ZLoOut, regIn[ra]; -> T0. mul/div: ZLoOut, LoIn; -> T6.
//  - T6 (mul/div only): ZHiOut, HiIn; -> T0.
//  - stop sampled only in the last state of an instruction (T5 ALU, T6 mul/div, T3 nop/illegal):
//    if 1, go HALT_S instead of T0. stop during fetch/T4 ignored until the boundary.
//  - HALT_S: all strobes 0, run=0; left only via clear.
//  - Latency: ALU 6 cycles, mul/div 7, nop 4 (zero wait states); +1 per T1 wait cycle.
//  - regIn/regOut never have more than one bit set; at most one bus driver asserted per cycle.
//  - ra/rb/rc=0 drive bit 0 as-is (no R0 special case).
// TESTING
//  1 Reset: clear=0 mid-T4 -> all outputs 0 same cycle; release -> T0 next posedge, run=1.
//  2 IR=0x521B8000 (op 01010, ra4 rb3 rc7), mem_ready=1 -> T3 regOut=0x0008, T4 regOut=0x0080
//    ALUcode=01010, T5 regIn=0x0010 ZLoOut=1, back to T0; 6 cycles total.
//  3 mul op 01111 rb=2 rc=5 -> T5 LoIn, T6 HiIn+ZHiOut, regIn stays 0; 7 cycles.
//  4 mem_ready low 3 cycles in T1 -> memRead held 4 cycles, then T2; low 16 cycles -> bus_error=1,
//    HALT_S, run=0; persists until clear.
//  5 stop=1 asserted in T1 of ALU instr -> instr completes, HALT_S after T5; halt opcode -> HALT_S after T3.
//  6 op 11111 with ILLEGAL_HALT=0 -> illegal_op pulse in T3, next state T0; =1 -> HALT_S.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the DataPath. It fetches each instruction through
// PC/MAR/MDR/IR, decodes the IR, and sequences the T-state control strobes.
// Supported instructions are three-register ALU ops, mul/div, nop and halt.
//
// Instruction fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
//
// Parameters
//   MEM_TIMEOUT   most cycles spent in T1 waiting for mem_ready before bus_error
//   ILLEGAL_HALT  1: an illegal opcode halts the CPU; 0: it behaves as nop
//
// Ports
//   clock        system clock; all state changes on posedge
//   clear        asynchronous, active-low reset
//   IR           instruction register contents (valid from T3 onward)
//   mem_ready    memory read data is valid this cycle
//   stop         level request to halt at the next instruction boundary
//   regIn        one-hot general-register load enables
//   regOut       one-hot general-register bus drive enables
//   PCOut .. LoIn  single-bit datapath strobes
//   memRead      memory read request, held while waiting
//   ALUcode      ALU operation select
//   run          1 while executing; 0 in RESET_S and HALT_S
//   illegal_op   one-cycle pulse in T3 on an undefined opcode
//   bus_error    sticky memory-timeout flag, cleared only by clear
//   state        current state encoding (debug)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] regIn,
  output logic [15:0] regOut,
  output logic        PCOut,
  output logic        PCIn,
  output logic        IncPC,
  output logic        MARIn,
  output logic        MDRIn,
  output logic        MDRread,
  output logic        MDROut,
  output logic        IRIn,
  output logic        YIn,
  output logic        ZIn,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        HiIn,
  output logic        LoIn,
  output logic        memRead,
  output logic [4:0]  ALUcode,
  output logic        run,
  output logic        illegal_op,
  output logic        bus_error,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    T0_S    = 4'd1,
    T1_S    = 4'd2,
    T2_S    = 4'd3,
    T3_S    = 4'd4,
    T4_S    = 4'd5,
    T5_S    = 4'd6,
    T6_S    = 4'd7,
    HALT_S  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MULDIV,
    C_NOP,
    C_HALT,
    C_ILLEGAL
  } op_class_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          cur_state;
  op_class_t       op_class;
  logic [CW-1:0]   wait_cnt;
  logic [4:0]      op;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [3:0]      rc;
  logic            unused_ir;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];

  // The low instruction bits carry no meaning for this instruction subset.
  assign unused_ir = ^IR[14:0];

  assign state = cur_state;

  // Opcode classification.
  always_comb begin
    op_class = C_ILLEGAL;
    if (op <= 5'b01100) begin
      op_class = C_ALU;
    end else begin
      case (op)
        5'b01111, 5'b10000: op_class = C_MULDIV;
        5'b11010:           op_class = C_NOP;
        5'b11011:           op_class = C_HALT;
        default:            op_class = C_ILLEGAL;
      endcase
    end
  end

  // State sequencing, memory-wait timeout and the sticky bus error.
  // At an instruction boundary, stop diverts the sequencer to HALT_S instead of T0.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_state <= RESET_S;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // here updates from the values present before this clock edge.
      case (cur_state)
        RESET_S: cur_state <= T0_S;
        T0_S: begin
          cur_state <= T1_S;
          wait_cnt  <= '0;
        end
        T1_S: begin
          if (mem_ready) begin
            cur_state <= T2_S;
            wait_cnt  <= '0;
          end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
            // This was the last permitted wait cycle.
            cur_state <= HALT_S;
            bus_error <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        T2_S: cur_state <= T3_S;
        T3_S: begin
          case (op_class)
            C_ALU, C_MULDIV: cur_state <= T4_S;
            C_HALT:          cur_state <= HALT_S;
            C_ILLEGAL:       cur_state <= (ILLEGAL_HALT || stop) ? HALT_S : T0_S;
            default:         cur_state <= stop ? HALT_S : T0_S;
          endcase
        end
        T4_S: cur_state <= T5_S;
        T5_S: begin
          if (op_class == C_MULDIV) cur_state <= T6_S;
          else                      cur_state <= stop ? HALT_S : T0_S;
        end
        T6_S:    cur_state <= stop ? HALT_S : T0_S;
        HALT_S:  cur_state <= HALT_S;
        default: cur_state <= RESET_S;
      endcase
    end
  end

  // Moore decode of the state and the IR fields. IR is only consulted from
  // T3 onward, because it is loaded during T2.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves one unassigned (which would infer a latch).
    regIn      = '0;
    regOut     = '0;
    PCOut      = 1'b0;
    PCIn       = 1'b0;
    IncPC      = 1'b0;
    MARIn      = 1'b0;
    MDRIn      = 1'b0;
    MDRread    = 1'b0;
    MDROut     = 1'b0;
    IRIn       = 1'b0;
    YIn        = 1'b0;
    ZIn        = 1'b0;
    ZHiOut     = 1'b0;
    ZLoOut     = 1'b0;
    HiIn       = 1'b0;
    LoIn       = 1'b0;
    memRead    = 1'b0;
    ALUcode    = '0;
    illegal_op = 1'b0;
    run        = (cur_state != RESET_S) && (cur_state != HALT_S);

    case (cur_state)
      T0_S: begin
        PCOut = 1'b1;
        MARIn = 1'b1;
        IncPC = 1'b1;
        ZIn   = 1'b1;
      end
      T1_S: begin
        ZLoOut  = 1'b1;
        PCIn    = 1'b1;
        memRead = 1'b1;
        MDRread = 1'b1;
        MDRIn   = 1'b1;
      end
      T2_S: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
      end
      T3_S: begin
        if (op_class == C_ALU || op_class == C_MULDIV) begin
          regOut = 16'd1 << rb;
          YIn    = 1'b1;
        end
        illegal_op = (op_class == C_ILLEGAL);
      end
      T4_S: begin
        regOut  = 16'd1 << rc;
        ALUcode = op;
        ZIn     = 1'b1;
      end
      T5_S: begin
        ZLoOut = 1'b1;
        if (op_class == C_MULDIV) LoIn  = 1'b1;
        else                      regIn = 16'd1 << ra;
      end
      T6_S: begin
        ZHiOut = 1'b1;
        HiIn   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. A second instance, built with
// ILLEGAL_HALT=1, shares all of the inputs so that both illegal-opcode
// behaviours can be observed from a single stimulus stream. Inputs are driven
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_HALT = 4'd8;

  // Bit positions inside the packed strobe vector below.
  localparam logic [14:0] M_PCOUT  = 15'h4000, M_PCIN   = 15'h2000, M_INCPC  = 15'h1000,
                          M_MARIN  = 15'h0800, M_MDRIN  = 15'h0400, M_MDRRD  = 15'h0200,
                          M_MDROUT = 15'h0100, M_IRIN   = 15'h0080, M_YIN    = 15'h0040,
                          M_ZIN    = 15'h0020, M_ZHIOUT = 15'h0010, M_ZLOOUT = 15'h0008,
                          M_HIIN   = 15'h0004, M_LOIN   = 15'h0002, M_MEMRD  = 15'h0001;

  localparam logic [14:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [14:0] E_T1 = M_ZLOOUT | M_PCIN | M_MEMRD | M_MDRRD | M_MDRIN;
  localparam logic [14:0] E_T2 = M_MDROUT | M_IRIN;

  logic        clock, clear, mem_ready, stop;
  logic [31:0] IR;

  logic [15:0] regIn, regOut;
  logic        PCOut, PCIn, IncPC, MARIn, MDRIn, MDRread, MDROut, IRIn;
  logic        YIn, ZIn, ZHiOut, ZLoOut, HiIn, LoIn, memRead;
  logic [4:0]  ALUcode;
  logic        run, illegal_op, bus_error;
  logic [3:0]  state;

  logic [15:0] h_regIn, h_regOut;
  logic        h_PCOut, h_PCIn, h_IncPC, h_MARIn, h_MDRIn, h_MDRread, h_MDROut, h_IRIn;
  logic        h_YIn, h_ZIn, h_ZHiOut, h_ZLoOut, h_HiIn, h_LoIn, h_memRead;
  logic [4:0]  h_ALUcode;
  logic        h_run, h_illegal_op, h_bus_error;
  logic [3:0]  h_state;

  logic [14:0] strobes;
  assign strobes = {PCOut, PCIn, IncPC, MARIn, MDRIn, MDRread, MDROut, IRIn,
                    YIn, ZIn, ZHiOut, ZLoOut, HiIn, LoIn, memRead};

  control_sequencer #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b0)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .regIn(regIn), .regOut(regOut), .PCOut(PCOut), .PCIn(PCIn), .IncPC(IncPC),
    .MARIn(MARIn), .MDRIn(MDRIn), .MDRread(MDRread), .MDROut(MDROut), .IRIn(IRIn),
    .YIn(YIn), .ZIn(ZIn), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .HiIn(HiIn), .LoIn(LoIn),
    .memRead(memRead), .ALUcode(ALUcode), .run(run), .illegal_op(illegal_op),
    .bus_error(bus_error), .state(state)
  );

  control_sequencer #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b1)) dut_ih (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .regIn(h_regIn), .regOut(h_regOut), .PCOut(h_PCOut), .PCIn(h_PCIn), .IncPC(h_IncPC),
    .MARIn(h_MARIn), .MDRIn(h_MDRIn), .MDRread(h_MDRread), .MDROut(h_MDROut), .IRIn(h_IRIn),
    .YIn(h_YIn), .ZIn(h_ZIn), .ZHiOut(h_ZHiOut), .ZLoOut(h_ZLoOut), .HiIn(h_HiIn), .LoIn(h_LoIn),
    .memRead(h_memRead), .ALUcode(h_ALUcode), .run(h_run), .illegal_op(h_illegal_op),
    .bus_error(h_bus_error), .state(h_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  // Hold clear low for a cycle, release it, and end at the first T0 sample.
  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0; stop = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic check_invariants();
    int drivers;
    drivers = int'(PCOut) + int'(MDROut) + int'(ZHiOut) + int'(ZLoOut) + int'(regOut != 16'd0);
    check("regIn_onehot",  32'($countones(regIn)  <= 1), 32'd1);
    check("regOut_onehot", 32'($countones(regOut) <= 1), 32'd1);
    check("one_bus_driver", 32'(drivers <= 1), 32'd1);
  endtask

  // Runs one instruction from a T0 sample until the next T0 or HALT_S sample.
  // 'waits' is the number of T1 cycles with mem_ready low before the data arrives.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int waits,
                           input bit stop_t1, input int exp_cycles,
                           input logic [3:0] exp_end, input int exp_illegal);
    int n, t1, ill, exp_t1;
    n = 0; t1 = 0; ill = 0;
    exp_t1 = (waits >= 16) ? 16 : waits + 1;
    IR = ir;
    do begin
      tick();
      n++;
      if (state == S_T1) begin
        t1++;
        mem_ready = (t1 > waits);
        if (stop_t1 && t1 == 1) stop = 1'b1;
      end
      if (illegal_op) ill++;
      check_invariants();
    end while (state != S_T0 && state != S_HALT && n < 64);
    check({tag, "_cycles"},     n,   exp_cycles);
    check({tag, "_end_state"},  {28'd0, state}, {28'd0, exp_end});
    check({tag, "_memread"},    t1,  exp_t1);
    check({tag, "_illegal"},    ill, exp_illegal);
    mem_ready = 1'b1;
  endtask

  initial begin
    clear = 1'b1; IR = '0; mem_ready = 1'b1; stop = 1'b0;
    #2 clear = 1'b0;

    // Reset state, then release into T0.
    tick(); tick();
    check("rst_state",   {28'd0, state}, {28'd0, S_RESET});
    check("rst_run",     run, 0);
    check("rst_strobes", strobes, 0);
    check("rst_regs",    {regIn, regOut}, 0);
    check("rst_alucode", ALUcode, 0);
    check("rst_buserr",  bus_error, 0);
    clear = 1'b1;
    tick();
    check("t0_state",   {28'd0, state}, {28'd0, S_T0});
    check("t0_run",     run, 1);
    check("t0_strobes", strobes, E_T0);

    // ALU op 01010, ra=4 rb=3 rc=7, with no memory wait states.
    IR = 32'h521B8000;
    tick();
    check("alu_t1_state",   {28'd0, state}, {28'd0, S_T1});
    check("alu_t1_strobes", strobes, E_T1);
    tick();
    check("alu_t2_strobes", strobes, E_T2);
    tick();
    check("alu_t3_regout",  regOut, 16'h0008);
    check("alu_t3_strobes", strobes, M_YIN);
    tick();
    check("alu_t4_regout",  regOut, 16'h0080);
    check("alu_t4_alucode", ALUcode, 5'b01010);
    check("alu_t4_strobes", strobes, M_ZIN);
    tick();
    check("alu_t5_regin",   regIn, 16'h0010);
    check("alu_t5_regout",  regOut, 0);
    check("alu_t5_strobes", strobes, M_ZLOOUT);
    tick();
    check("alu_back_t0",    {28'd0, state}, {28'd0, S_T0});

    // mul: rb=2 rc=5, ra=9 must never be loaded.
    IR = mk_ir(5'b01111, 4'd9, 4'd2, 4'd5);
    tick(); tick(); tick();
    check("mul_t3_regout",  regOut, 16'h0004);
    tick();
    check("mul_t4_regout",  regOut, 16'h0020);
    check("mul_t4_alucode", ALUcode, 5'b01111);
    tick();
    check("mul_t5_strobes", strobes, M_ZLOOUT | M_LOIN);
    check("mul_t5_regin",   regIn, 0);
    tick();
    check("mul_t6_state",   {28'd0, state}, {28'd0, S_T6});
    check("mul_t6_strobes", strobes, M_ZHIOUT | M_HIIN);
    check("mul_t6_regin",   regIn, 0);
    tick();
    check("mul_back_t0",    {28'd0, state}, {28'd0, S_T0});

    // Latency and wait-state behaviour.
    run_instr("div",   mk_ir(5'b10000, 4'd1, 4'd15, 4'd0), 0,  1'b0, 7,  S_T0, 0);
    run_instr("nop",   mk_ir(5'b11010, 4'd0, 4'd0, 4'd0),  0,  1'b0, 4,  S_T0, 0);
    run_instr("wait3", mk_ir(5'b00001, 4'd2, 4'd3, 4'd4),  3,  1'b0, 9,  S_T0, 0);
    run_instr("wait15", mk_ir(5'b01100, 4'd0, 4'd0, 4'd0), 15, 1'b0, 21, S_T0, 0);
    check("wait15_buserr", bus_error, 0);

    // Illegal opcode: continues in this instance, halts the ILLEGAL_HALT one.
    run_instr("illegal", mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b0, 4, S_T0, 1);
    check("ih_state", {28'd0, h_state}, {28'd0, S_HALT});
    check("ih_run",   h_run, 0);

    // clear asserted mid-T4 forces every output low before the next edge.
    IR = 32'h521B8000;
    tick(); tick(); tick(); tick();
    check("mid_t4_state", {28'd0, state}, {28'd0, S_T4});
    clear = 1'b0;
    #1;
    check("mid_rst_state",   {28'd0, state}, {28'd0, S_RESET});
    check("mid_rst_strobes", strobes, 0);
    check("mid_rst_regs",    {regIn, regOut}, 0);
    check("mid_rst_alucode", ALUcode, 0);
    check("mid_rst_flags",   {run, illegal_op, bus_error}, 0);
    tick();
    clear = 1'b1;
    tick();
    check("mid_rst_t0",  {28'd0, state}, {28'd0, S_T0});
    check("mid_rst_run", run, 1);

    // stop raised during fetch: the instruction completes, then HALT_S.
    run_instr("stop", 32'h521B8000, 0, 1'b1, 6, S_HALT, 0);
    tick(); tick(); tick();
    check("stop_hold_state",   {28'd0, state}, {28'd0, S_HALT});
    check("stop_hold_run",     run, 0);
    check("stop_hold_strobes", strobes, 0);
    do_reset();

    // halt opcode.
    run_instr("halt", mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 1'b0, 4, S_HALT, 0);
    check("halt_run", run, 0);
    do_reset();

    // Memory timeout: the sixteenth wait cycle raises a sticky bus_error.
    run_instr("timeout", 32'h521B8000, 16, 1'b0, 17, S_HALT, 0);
    check("timeout_buserr", bus_error, 1);
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("timeout_sticky", bus_error, 1);
    check("timeout_halted", {28'd0, state}, {28'd0, S_HALT});
    clear = 1'b0;
    #1;
    check("timeout_cleared", bus_error, 0);
    tick();
    clear = 1'b1;
    tick();
    check("timeout_restart", {28'd0, state}, {28'd0, S_T0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
